// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the sequential FIR MAC engine.
package fir_pkg;

    localparam int TAPS_DEF  = 8;
    localparam int ACC_W_DEF = 19;
    localparam int MULT_W    = 16;
    localparam int SAMPLE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sample/result handshake and coefficient write port of the FIR MAC engine.
interface fir_mac_seq_if
    import fir_pkg::*;
#(
    parameter int TAPS  = TAPS_DEF,
    parameter int ACC_W = ACC_W_DEF
);

    logic                     in_valid;
    logic                     in_ready;
    logic [SAMPLE_W-1:0]      in_data;
    logic                     coef_we;
    logic [$clog2(TAPS)-1:0]  coef_addr;
    logic [SAMPLE_W-1:0]      coef_wdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_data;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mul_8bit.sv
// Combinational 8x8 unsigned multiplier; C is the carry beyond 16 bits (always 0).
module mul_8bit (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P,
    output logic        C
);

    assign {C, P} = 17'(A) * 17'(B);

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one tap per cycle through mul_8bit, one result per accepted sample.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int TAPS  = TAPS_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_mac_seq_if.slave  bus
);

    localparam int              CNT_W    = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    out_q, out_d;
    logic [SAMPLE_W-1:0] x_q [TAPS];
    logic [SAMPLE_W-1:0] h_q [TAPS];

    logic [SAMPLE_W-1:0] mul_a, mul_b;
    logic [MULT_W-1:0]   mul_p;
    logic                mul_c;
    logic [ACC_W-1:0]    sum;
    logic                accept;
    logic                coef_wr;

    assign mul_a = x_q[cnt_q];
    assign mul_b = h_q[cnt_q];

    mul_8bit u_mul (
        .A (mul_a),
        .B (mul_b),
        .P (mul_p),
        .C (mul_c)
    );

    assign sum     = acc_q + ACC_W'({mul_c, mul_p});
    assign accept  = (state_q == IDLE) && bus.in_valid;
    // Coefficients are frozen outside IDLE so a running sum never sees a mix.
    assign coef_wr = (state_q == IDLE) && bus.coef_we;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_TAP) begin
                    out_d   = sum;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    // NOTE: the delay line and coefficient bank are flop arrays with reset, since a
    // sample after reset must see zero history and zero taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                x_q[0] <= bus.in_data;
                for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
            end
            if (coef_wr) h_q[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: directed samples push expected results, a monitor pops and compares.
module tb_fir_mac_seq;
    import fir_pkg::*;

    localparam int TAPS  = 8;
    localparam int ACC_W = 19;
    localparam int CA_W  = $clog2(TAPS);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fir_mac_seq_if #(.TAPS(TAPS), .ACC_W(ACC_W)) bus ();

    fir_mac_seq #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_accept = 0;
    bit ov_prev  = 1'b0;
    int exp_q[$];
    int acc_cyc_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: accept timestamps, output latency and scoreboard compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc_q.push_back(cyc);
                n_accept++;
            end
            if (bus.out_valid && !ov_prev) begin
                if (acc_cyc_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL latency: out_valid rose with no accepted sample (t=%0t)", $time);
                end else begin
                    check("latency", cyc - acc_cyc_q.pop_front(), TAPS + 1);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_data: unexpected result %0d (t=%0t)", bus.out_data, $time);
                end else begin
                    check("out_data", int'(bus.out_data), exp_q.pop_front());
                end
            end
            ov_prev = bus.out_valid;
        end
        cyc++;
    end

    task automatic write_coef(input int addr, input int data);
        @(posedge clk); #1;
        bus.coef_we    = 1'b1;
        bus.coef_addr  = CA_W'(addr);
        bus.coef_wdata = 8'(data);
        @(posedge clk); #1;
        bus.coef_we    = 1'b0;
    endtask

    task automatic send(input int data, input int exp, input bit expect_out);
        int budget = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("send_in_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(data);
        if (expect_out) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() > 0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        int acc0;
        int budget;
        int acc_at [3];
        int n_b2b;
        int t;

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_in_ready",  int'(bus.in_ready), 1);
        check("reset_out_data",  int'(bus.out_data), 0);

        // Impulse response with h = 1..8.
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        for (int k = 0; k < TAPS; k++) send((k == 0) ? 1 : 0, k + 1, 1'b1);
        drain();

        // Full scale: every product 255*255, sums climb to 520200.
        for (int k = 0; k < TAPS; k++) write_coef(k, 255);
        for (int k = 0; k < TAPS; k++) send(255, 65025 * (k + 1), 1'b1);
        drain();

        // Backpressure: x becomes [0, 255 x7] -> 7*65025.
        bus.out_ready = 1'b0;
        send(0, 455175, 1'b1);
        budget = 0;
        while (!bus.out_valid && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        check("bp_out_valid_seen", int'(bus.out_valid), 1);
        held = int'(bus.out_data);
        check("bp_held_value", held, 455175);
        acc0 = n_accept;
        repeat (5) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd77;
            @(negedge clk);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_out_data",  int'(bus.out_data), held);
            check("bp_in_ready",  int'(bus.in_ready), 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_no_accept", n_accept - acc0, 0);
        bus.out_ready = 1'b1;
        drain();
        // x = [0,0,255 x6]; a consumed 77 would change this result.
        send(0, 390150, 1'b1);
        drain();

        // Coefficient gating: h = 1..8, write of h[0]=9 during MAC is dropped.
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        send(10, 7660, 1'b1);
        @(posedge clk); #1;
        bus.coef_we    = 1'b1;
        bus.coef_addr  = '0;
        bus.coef_wdata = 8'd9;
        repeat (3) @(posedge clk);
        #1 bus.coef_we = 1'b0;
        drain();
        send(20, 6670, 1'b1);
        drain();
        write_coef(0, 9);
        send(30, 5695, 1'b1);
        drain();

        // Reset in the middle of MAC: no result, everything cleared.
        send(40, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", int'(bus.out_valid), 0);
        check("rst_mid_in_ready",  int'(bus.in_ready), 1);
        check("rst_mid_out_data",  int'(bus.out_data), 0);
        write_coef(0, 3);
        send(5, 15, 1'b1);
        drain();

        // Back-to-back with in_valid held: h[0]=3 only, data 2 -> 6 each.
        n_b2b = 0;
        t = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd2;
        while (n_b2b < 3 && t < 100) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_at[n_b2b] = t;
                n_b2b++;
                exp_q.push_back(6);
            end
            t++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_accepts", n_b2b, 3);
        check("b2b_period_1", acc_at[1] - acc_at[0], TAPS + 2);
        check("b2b_period_2", acc_at[2] - acc_at[1], TAPS + 2);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Time-multiplexed FIR filter engine that sits directly downstream of the team's 8×8 unsigned multiplier `mul_8bit`. It owns the tap delay line and coefficient registers, and drives the multiplier's A and B inputs one tap per cycle. It accumulates the 16-bit products into a wide sum and emits one filtered output per accepted input sample. Input and output use valid/ready handshakes.

## Interface
Parameters:
- `TAPS`, default 8: number of filter taps; must be ≥ 2.
- `ACC_W`, default 19: accumulator/output width; must be ≥ 16 + clog2(TAPS).

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: engine can accept a sample.
- `in_data`, in, 8: unsigned input sample x[n].
- `coef_we`, in, 1: coefficient write strobe.
- `coef_addr`, in, clog2(TAPS): coefficient index k.
- `coef_wdata`, in, 8: unsigned coefficient h[k].
- `out_valid`, out, 1: filtered result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, ACC_W: y[n] = Σ h[k]·x[n−k], unsigned.

## Operation
- **Reset:**
  - state = IDLE, `in_ready` = 1, `out_valid` = 0, `out_data` = 0.
  - Delay line x[0..TAPS−1] = 0, coefficients h[0..TAPS−1] = 0.
  - Tap counter = 0, accumulator = 0.
- **FSM states:** IDLE, MAC, OUT.
- **IDLE:**
  - `in_ready` = 1.
  - When `in_valid`&&`in_ready`, the delay line shifts: x[0] ← `in_data` and x[i] ← x[i−1]; the old x[TAPS−1] is discarded.
  - Accumulator ← 0, counter ← 0, go to MAC.
- **MAC:**
  - `in_ready` = 0.
  - Each cycle, `mul_8bit` gets A = x[cnt] and B = h[cnt], and the accumulator adds the zero-extended P.
  - Counter increments each cycle. After the cycle with cnt = TAPS−1, `out_data` ← final sum and the FSM goes to OUT.
- **OUT:**
  - `out_valid` = 1 and `out_data` is held stable.
  - On `out_valid`&&`out_ready`, go to IDLE. `out_valid` drops the next cycle; `out_data` keeps its last value.
- **Coefficient writes:**
  - Take effect only while state = IDLE: h[`coef_addr`] ← `coef_wdata` at the edge.
  - Ignored in MAC/OUT, so coefficients never change mid-computation.
  - A write in IDLE on the same edge as a sample accept is applied. The new coefficient is used for that sample, because MAC reads it in later cycles.
- **Arithmetic:**
  - Fully unsigned. The multiplier carry output `C` is unused (always 0 for 8×8).
  - No saturation or overflow. At the defaults, the maximum is 8·255·255 = 520200 < 2^19.
- **Reset mid-operation:** asynchronous return to reset values from any state. A partial sum is lost and no output is produced.

## Timing
- **Sample accept:** edge E0, state IDLE.
- **MAC:** runs in the TAPS cycles after E0. The last accumulate is at edge E_TAPS.
- **Output:** `out_valid` rises in the cycle after E_TAPS, i.e. latency = TAPS+1 cycles from the accept edge.
- **Minimum sample period:** TAPS+2 cycles, with `out_ready` tied high (1 IDLE + TAPS MAC + 1 OUT).
- **`in_ready`** is registered. It is high only in IDLE and never combinationally depends on `out_ready`.
- **Multiplier path:** combinational. x[cnt]/h[cnt] mux → `mul_8bit` → adder → accumulator register, within one cycle.
- **Backpressure:** indefinite `out_ready` low holds OUT. `out_data` is stable and no samples are accepted.

## Structure
- **Shared package `fir_pkg`:**
  - default TAPS and ACC_W constants;
  - MULT_W = 16 and SAMPLE_W = 8;
  - the FSM state enum {IDLE, MAC, OUT}.
- **Sub-module:** one instance of the existing `mul_8bit`. Delay line, coefficient bank, counter, accumulator and FSM are local to `fir_mac_seq`.

## Test plan
- **Impulse response:** load h = 1,2,…,8; send 1 then seven 0s with `out_ready`=1.
  - Required: outputs 1,2,3,4,5,6,7,8.
  - Each output has `out_valid` exactly TAPS+1 = 9 cycles after its accept.
- **Full-scale:** all h = 255; send eight samples of 255.
  - Required: outputs 65025, 130050, …, 520200.
  - No wrap on ACC_W = 19.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in OUT.
  - Required: `out_valid` stays 1, `out_data` is unchanged, `in_ready` = 0.
  - `in_valid` asserted during this window is not consumed.
- **Coefficient write gating:** write h[0] = 9 during MAC.
  - Required: the current and next outputs use the old h[0].
  - The same write issued in IDLE affects the next sample.
- **Reset mid-MAC:** assert `rst_n`=0 at MAC cycle 4.
  - Required: `out_valid`=0 and `in_ready`=1 immediately after deassertion.
  - The delay line and coefficients are zero, so the next sample of 5 with h[0] = 3 written yields 15.
- **Back-to-back:** `in_valid` held high with `out_ready`=1.
  - Required: one accept every 10 cycles with the default TAPS = 8.
